// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// write-back stage (priority) and the multiply/divide unit. MDU results wait in
// a small FIFO; a starvation guard forces a one-cycle pipeline stall so the
// FIFO head can drain.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_we,
  input  logic [ADDR_W-1:0]          pipe_wreg,
  input  logic [DATA_W-1:0]          pipe_wdata,
  input  logic                       mdu_valid,
  output logic                       mdu_ready,
  input  logic [ADDR_W-1:0]          mdu_wreg,
  input  logic [DATA_W-1:0]          mdu_wdata,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       pipe_stall,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_BYP} grant_e;

  // FIFO storage kept in flops: squash needs every entry's wreg in parallel
  logic [ADDR_W-1:0] wreg_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [DEPTH-1:0]  occ;
  logic [DEPTH-1:0]  sq_hit;
  logic              head_present, head_valid, any_valid;
  logic              hs, push, pop;
  grant_e            grant;

  // Per-slot occupancy (slot lies within count entries of the read pointer)
  // and match against the pipeline destination for squashing.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] off;
      assign off        = PTR_W'(gi) - rd_ptr_q;
      assign occ[gi]    = ({1'b0, off} < count_q);
      assign sq_hit[gi] = occ[gi] && (wreg_q[gi] == pipe_wreg);
    end
  endgenerate

  assign head_present = (count_q != '0);
  assign head_valid   = head_present && vld_q[rd_ptr_q];
  assign any_valid    = |(vld_q & occ);
  assign mdu_ready    = (count_q < CNT_W'(DEPTH));
  assign hs           = mdu_valid && mdu_ready;

  // Grant selection, first matching rule wins; a forced stall ignores the pipeline.
  always_comb begin
    grant = GNT_NONE;
    if (stall_q) begin
      if (head_valid) grant = GNT_FIFO;
    end else if (pipe_we && (pipe_wreg != '0)) begin
      grant = GNT_PIPE;
    end else if (head_valid) begin
      grant = GNT_FIFO;
    end else if (!head_present && hs && (mdu_wreg != '0)) begin
      grant = GNT_BYP;
    end
  end

  // FIFO bookkeeping: squashed heads are dropped regardless of the grant,
  // r0 results are accepted but never stored.
  always_comb begin
    pop     = (grant == GNT_FIFO) || (head_present && !vld_q[rd_ptr_q]);
    push    = hs && (grant != GNT_BYP) && (mdu_wreg != '0);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    vld_d   = vld_q;
    if (grant == GNT_PIPE) vld_d = vld_d & ~sq_hit;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if ((grant == GNT_FIFO) || !any_valid) starve_d = '0;
    else if (head_valid)                   starve_d = starve_q + ST_W'(1);
    else                                   starve_d = starve_q;
    stall_d = (starve_d == ST_W'(STARVE_LIMIT));
  end

  // Write-port data for the granted source; address/data hold when idle.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (grant)
      GNT_PIPE: begin rf_we_d = 1'b1; rf_waddr_d = pipe_wreg;        rf_wdata_d = pipe_wdata;        end
      GNT_FIFO: begin rf_we_d = 1'b1; rf_waddr_d = wreg_q[rd_ptr_q]; rf_wdata_d = wdata_q[rd_ptr_q]; end
      GNT_BYP:  begin rf_we_d = 1'b1; rf_waddr_d = mdu_wreg;         rf_wdata_d = mdu_wdata;         end
      default:  ;
    endcase
  end

  // Control state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      vld_q      <= vld_d;
      rd_ptr_q   <= pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_q   <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload storage; validity lives in vld_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      wreg_q[wr_ptr_q]  <= mdu_wreg;
      wdata_q[wr_ptr_q] <= mdu_wdata;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = stall_q;
  assign buf_count  = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_we = 1'b0;
  logic [AW-1:0] pipe_wreg = '0;
  logic [DW-1:0] pipe_wdata = '0;
  logic          mdu_valid = 1'b0;
  logic          mdu_ready;
  logic [AW-1:0] mdu_wreg = '0;
  logic [DW-1:0] mdu_wdata = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pipe_stall;
  logic [1:0]    buf_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wreg(mdu_wreg), .mdu_wdata(mdu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          wreg;
    logic [DW-1:0] data;
    bit          v;
  } ent_t;

  ent_t          m_q[$];
  int            m_starve;
  bit            m_stall;
  bit            m_we;
  int            m_waddr;
  logic [DW-1:0] m_wdata;
  bit            exp_ready;
  logic          obs_ready;

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_stall = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
  endtask

  // One clock cycle: evaluate the rules on the current inputs, advance the
  // DUT clock, leave time at edge+1 for sampling.
  task automatic cyc();
    int   sz, g;
    bit   hs, hv, anyv, pop;
    ent_t e;
    sz   = m_q.size();
    exp_ready = (sz < DEPTH);
    obs_ready = mdu_ready;
    hs   = mdu_valid && exp_ready;
    hv   = (sz > 0) && m_q[0].v;
    anyv = 0;
    foreach (m_q[i]) if (m_q[i].v) anyv = 1;
    g = 0;
    if (m_stall) g = hv ? 2 : 0;
    else if (pipe_we && pipe_wreg != 0) g = 1;
    else if (hv) g = 2;
    else if (sz == 0 && hs && mdu_wreg != 0) g = 3;
    m_we = (g != 0);
    if (g == 1) begin m_waddr = int'(pipe_wreg); m_wdata = pipe_wdata; end
    if (g == 2) begin m_waddr = m_q[0].wreg;    m_wdata = m_q[0].data; end
    if (g == 3) begin m_waddr = int'(mdu_wreg);  m_wdata = mdu_wdata;  end
    pop = (g == 2) || (sz > 0 && !hv);
    if (g == 1) foreach (m_q[i]) if (m_q[i].wreg == int'(pipe_wreg)) m_q[i].v = 0;
    if (g == 2 || !anyv) m_starve = 0;
    else if (hv) m_starve = m_starve + 1;
    m_stall = (m_starve == LIMIT);
    if (pop) void'(m_q.pop_front());
    if (hs && g != 3 && mdu_wreg != 0) begin
      e.wreg = int'(mdu_wreg); e.data = mdu_wdata; e.v = 1;
      m_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit pw, int pr, logic [DW-1:0] pd, bit mv, int mr, logic [DW-1:0] md);
    pipe_we = pw; pipe_wreg = AW'(pr); pipe_wdata = pd;
    mdu_valid = mv; mdu_wreg = AW'(mr); mdu_wdata = md;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    n_checks++; if (rf_waddr !== '0) begin n_errors++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    n_checks++; if (rf_wdata !== '0) begin n_errors++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %0b want 0", pipe_stall); end
    n_checks++; if (buf_count !== 2'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", buf_count); end
    n_checks++; if (mdu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %0b want 1", mdu_ready); end
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_pipe();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0); cyc();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL pipe_write got we=%0b a=%0d d=%h want we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
    drive(1, 0, 32'h12345678, 0, 0, 0); cyc();
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL pipe_r0 got we=%0b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd5) begin n_errors++; $display("FAIL pipe_hold_addr got %0d want 5", rf_waddr); end
    drive(0, 0, 0, 0, 0, 0); cyc();
    $display("test_pipe: done");
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 1, 8, 32'h1234); cyc();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234) begin
      n_errors++; $display("FAIL bypass got we=%0b a=%0d d=%h want we=1 a=8 d=1234", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (buf_count !== 2'd0) begin n_errors++; $display("FAIL bypass_count got %0d want 0", buf_count); end
    drive(0, 0, 0, 0, 0, 0); cyc();
    $display("test_bypass: done");
  endtask

  task automatic test_buffer_full();
    drive(1, 1, 32'h11, 1, 2, 32'h22); cyc();
    drive(1, 1, 32'h11, 1, 3, 32'h33); cyc();
    n_checks++; if (buf_count !== 2'd2 || mdu_ready !== 1'b0) begin
      n_errors++; $display("FAIL full_state got count=%0d ready=%0b want count=2 ready=0", buf_count, mdu_ready); end
    drive(1, 1, 32'h11, 1, 4, 32'h44); cyc();
    n_checks++; if (obs_ready !== 1'b0 || buf_count !== 2'd2) begin
      n_errors++; $display("FAIL full_holdoff got ready=%0b count=%0d want ready=0 count=2", obs_ready, buf_count); end
    drive(0, 0, 0, 1, 4, 32'h44); cyc();   // pop only, no pass-through
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22 || buf_count !== 2'd1 || obs_ready !== 1'b0) begin
      n_errors++; $display("FAIL full_pop got we=%0b a=%0d d=%h cnt=%0d rdy=%0b want 1/2/22/1/0", rf_we, rf_waddr, rf_wdata, buf_count, obs_ready); end
    drive(1, 1, 32'h11, 1, 4, 32'h44); cyc();   // push accepted now
    n_checks++; if (obs_ready !== 1'b1 || buf_count !== 2'd2) begin
      n_errors++; $display("FAIL full_refill got ready=%0b count=%0d want ready=1 count=2", obs_ready, buf_count); end
    drive(0, 0, 0, 0, 0, 0); cyc();
    n_checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
      n_errors++; $display("FAIL full_order1 got a=%0d d=%h want a=3 d=33", rf_waddr, rf_wdata); end
    cyc();
    n_checks++; if (rf_waddr !== 5'd4 || rf_wdata !== 32'h44 || buf_count !== 2'd0) begin
      n_errors++; $display("FAIL full_order2 got a=%0d d=%h cnt=%0d want a=4 d=44 cnt=0", rf_waddr, rf_wdata, buf_count); end
    $display("test_buffer_full: done");
  endtask

  task automatic test_starve();
    int stalls = 0, stall_idx = -1;
    logic [AW-1:0] a5 = '0, a6 = '0;
    logic [DW-1:0] d5 = '0;
    drive(1, 1, 32'hA0, 1, 7, 32'h77); cyc();   // index 0
    mdu_valid = 1'b0;
    if (pipe_stall === 1'b1) begin stalls++; stall_idx = 0; end
    for (int i = 1; i < 10; i++) begin
      pipe_wdata = 32'hA0 + i;
      cyc();
      if (pipe_stall === 1'b1) begin stalls++; stall_idx = i; end
      if (i == 5) begin a5 = rf_waddr; d5 = rf_wdata; end
      if (i == 6) a6 = rf_waddr;
    end
    n_checks++; if (stalls != 1 || stall_idx != 4) begin
      n_errors++; $display("FAIL starve_stall got stalls=%0d at=%0d want 1 at 4", stalls, stall_idx); end
    n_checks++; if (a5 !== 5'd7 || d5 !== 32'h77) begin
      n_errors++; $display("FAIL starve_drain got a=%0d d=%h want a=7 d=77", a5, d5); end
    n_checks++; if (a6 !== 5'd1) begin n_errors++; $display("FAIL starve_resume got a=%0d want 1", a6); end
    drive(0, 0, 0, 0, 0, 0); cyc();
    $display("test_starve: done");
  endtask

  task automatic test_squash();
    bit seen_a = 0;
    drive(1, 1, 32'h1, 1, 9, 32'hAAAA); cyc();
    drive(1, 9, 32'hBBBB, 1, 9, 32'hCCCC); cyc();
    n_checks++; if (rf_waddr !== 5'd9 || rf_wdata !== 32'hBBBB) begin
      n_errors++; $display("FAIL squash_pipe got a=%0d d=%h want a=9 d=bbbb", rf_waddr, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0); cyc();
    n_checks++; if (rf_we !== 1'b0 || buf_count !== 2'd1) begin
      n_errors++; $display("FAIL squash_drop got we=%0b cnt=%0d want we=0 cnt=1", rf_we, buf_count); end
    cyc();
    if (rf_we === 1'b1 && rf_wdata === 32'hAAAA) seen_a = 1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hCCCC) begin
      n_errors++; $display("FAIL squash_young got we=%0b a=%0d d=%h want we=1 a=9 d=cccc", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (seen_a) begin n_errors++; $display("FAIL squash_stale got aaaa written want none"); end
    $display("test_squash: done");
  endtask

  task automatic test_reset_midstream();
    drive(1, 1, 32'h5, 1, 2, 32'h6); cyc();
    drive(1, 1, 32'h5, 1, 3, 32'h7); cyc();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pipe_stall !== 1'b0 || buf_count !== 2'd0 || mdu_ready !== 1'b1) begin
      n_errors++; $display("FAIL midreset got we=%0b a=%0d d=%h st=%0b cnt=%0d rdy=%0b want all reset", rf_we, rf_waddr, rf_wdata, pipe_stall, buf_count, mdu_ready); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    n_checks++; if (rf_we !== 1'b0 || buf_count !== 2'd0 || mdu_ready !== 1'b1) begin
      n_errors++; $display("FAIL midreset_after got we=%0b cnt=%0d rdy=%0b want 0/0/1", rf_we, buf_count, mdu_ready); end
    $display("test_reset_midstream: done");
  endtask

  task automatic test_random();
    int errs0 = n_errors;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom);
      cyc();
      n_checks++;
      if (rf_we !== m_we || rf_waddr !== AW'(m_waddr) || rf_wdata !== m_wdata ||
          pipe_stall !== m_stall || buf_count !== 2'(m_q.size()) || obs_ready !== exp_ready) begin
        n_errors++;
        $display("FAIL random_cyc%0d got we=%0b a=%0d d=%h st=%0b cnt=%0d rdy=%0b want we=%0b a=%0d d=%h st=%0b cnt=%0d rdy=%0b",
                 i, rf_we, rf_waddr, rf_wdata, pipe_stall, buf_count, obs_ready,
                 m_we, m_waddr, m_wdata, m_stall, m_q.size(), exp_ready);
      end
    end
    $display("test_random: 400 cycles, %0d new errors", n_errors - errs0);
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_bypass();
    test_buffer_full();
    test_starve();
    test_squash();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
